// File: rtl/telemetry_packetizer_pkg.sv
// Shared types and CRC helper for the telemetry packetizer.
// The CRC state only exists when PKT_CRC_EN is defined.
package telemetry_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_SEQ,
      ST_DATA
`ifdef PKT_CRC_EN
      ,
      ST_CRC
`endif
   } pkt_state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // MSB-first CRC-8, no reflection, no final XOR; one byte per call.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/telemetry_packetizer_if.sv
// Word-in / byte-out bus of the telemetry packetizer; slave is the packetizer side.
interface telemetry_packetizer_if;

   logic        in_valid;
   logic [31:0] in_data;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic        overflow;
   logic [15:0] pkt_count;

   modport master (
      output in_valid, in_data, tx_ready,
      input  tx_byte, tx_valid, overflow, pkt_count
   );

   modport slave (
      input  in_valid, in_data, tx_ready,
      output tx_byte, tx_valid, overflow, pkt_count
   );

endinterface

// File: rtl/telemetry_packetizer_word_fifo.sv
// Synchronous 32-bit word FIFO with fall-through head and a one-ahead peek.
module telemetry_word_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata,
   output logic [31:0]            rdata_next,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A push at full is still taken when the same cycle frees a slot.
   assign do_push = push && (!full || do_pop);

   assign rd_next    = rd_ptr + 1'b1;
   assign rdata      = mem[rd_ptr];
   assign rdata_next = mem[rd_next];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_next;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/telemetry_packetizer.sv
// Telemetry packetizer: frames FIFO-buffered 32-bit words into SYNC/SEQ/payload byte packets.
// Defining PKT_CRC_EN appends a CRC-8 over the SEQ and payload bytes as the final byte.
module telemetry_packetizer
   import telemetry_pkg::*;
#(
   parameter int         WORDS_PER_PKT = 4,
   parameter int         FIFO_DEPTH    = 8,
   parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   telemetry_packetizer_if.slave bus
);

   localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] PKT_WORDS = WORDS_PER_PKT[CW-1:0];
   localparam logic [3:0]    LAST_WORD = 4'(WORDS_PER_PKT - 1);

   pkt_state_t    state;
   pkt_state_t    state_nxt;
   logic [1:0]    byte_idx;
   logic [1:0]    byte_idx_nxt;
   logic [3:0]    word_idx;
   logic [3:0]    word_idx_nxt;
   logic [7:0]    tx_byte_q;
   logic [7:0]    tx_byte_nxt;
   logic          tx_valid_q;
   logic          tx_valid_nxt;
   logic [7:0]    seq;
   logic [15:0]   pkt_cnt;
   logic          ovf;
   logic          hs;
   logic          pop;
   logic          pkt_done;
   logic [31:0]   head;
   logic [31:0]   head_next;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
`ifdef PKT_CRC_EN
   logic [7:0]    crc;
`endif

   telemetry_word_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .push      (bus.in_valid),
      .pop       (pop),
      .wdata     (bus.in_data),
      .rdata     (head),
      .rdata_next(head_next),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign hs            = tx_valid_q && bus.tx_ready;
   assign bus.tx_byte   = tx_byte_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.overflow  = ovf;
   assign bus.pkt_count = pkt_cnt;

   // tx_byte/tx_valid are computed one state ahead so the link sees registered outputs.
   always_comb begin
      state_nxt    = state;
      byte_idx_nxt = byte_idx;
      word_idx_nxt = word_idx;
      tx_byte_nxt  = tx_byte_q;
      tx_valid_nxt = tx_valid_q;
      pop          = 1'b0;
      pkt_done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && fifo_count >= PKT_WORDS) begin
               state_nxt    = ST_SYNC;
               tx_byte_nxt  = SYNC_BYTE;
               tx_valid_nxt = 1'b1;
            end
         end
         ST_SYNC: begin
            if (hs) begin
               state_nxt   = ST_SEQ;
               tx_byte_nxt = seq;
            end
         end
         ST_SEQ: begin
            if (hs) begin
               state_nxt    = ST_DATA;
               byte_idx_nxt = 2'd0;
               word_idx_nxt = 4'd0;
               tx_byte_nxt  = word_byte(head, 2'd0);
            end
         end
         ST_DATA: begin
            if (hs) begin
               if (byte_idx != 2'd3) begin
                  byte_idx_nxt = byte_idx + 2'd1;
                  tx_byte_nxt  = word_byte(head, byte_idx + 2'd1);
               end else begin
                  pop          = 1'b1;
                  byte_idx_nxt = 2'd0;
                  if (word_idx == LAST_WORD) begin
`ifdef PKT_CRC_EN
                     state_nxt    = ST_CRC;
                     tx_byte_nxt  = crc8_byte(crc, tx_byte_q);
`else
                     state_nxt    = ST_IDLE;
                     tx_byte_nxt  = 8'h00;
                     tx_valid_nxt = 1'b0;
                     pkt_done     = 1'b1;
`endif
                  end else begin
                     // The head is popped on this edge, so the next word is one slot ahead.
                     word_idx_nxt = word_idx + 4'd1;
                     tx_byte_nxt  = word_byte(head_next, 2'd0);
                  end
               end
            end
         end
`ifdef PKT_CRC_EN
         ST_CRC: begin
            if (hs) begin
               state_nxt    = ST_IDLE;
               tx_byte_nxt  = 8'h00;
               tx_valid_nxt = 1'b0;
               pkt_done     = 1'b1;
            end
         end
`endif
         default: begin
            state_nxt    = ST_IDLE;
            tx_byte_nxt  = 8'h00;
            tx_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         byte_idx   <= 2'd0;
         word_idx   <= 4'd0;
         tx_byte_q  <= 8'h00;
         tx_valid_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_idx   <= byte_idx_nxt;
         word_idx   <= word_idx_nxt;
         tx_byte_q  <= tx_byte_nxt;
         tx_valid_q <= tx_valid_nxt;
      end
   end

   // Overflow is sticky: only a dropped word (full, no pop this cycle) sets it.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         seq     <= 8'h00;
         pkt_cnt <= 16'h0000;
         ovf     <= 1'b0;
      end else begin
         if (pkt_done) begin
            seq     <= seq + 8'h01;
            pkt_cnt <= pkt_cnt + 16'h0001;
         end
         if (bus.in_valid && fifo_full && !pop) begin
            ovf <= 1'b1;
         end
      end
   end

`ifdef PKT_CRC_EN
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         crc <= 8'h00;
      end else if (state == ST_SYNC) begin
         crc <= 8'h00;
      end else if (hs && (state == ST_SEQ || state == ST_DATA)) begin
         crc <= crc8_byte(crc, tx_byte_q);
      end
   end
`endif

endmodule
